// File: rtl/regfile_writeback.sv
// Write-side initiator for the register file: merges single-cycle ALU results
// with FIFO-buffered load results into one registered write port, plus forwarding.
module regfile_writeback #(
  parameter int DATA_WIDTH  = 16,
  parameter int INDEX_WIDTH = 5,
  parameter int DEPTH       = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           alu_valid,
  input  logic [INDEX_WIDTH-1:0]         alu_index,
  input  logic [DATA_WIDTH-1:0]          alu_data,
  input  logic                           load_valid,
  output logic                           load_ready,
  input  logic [INDEX_WIDTH-1:0]         load_index,
  input  logic [DATA_WIDTH-1:0]          load_data,
  input  logic [INDEX_WIDTH-1:0]         rd_index_1,
  input  logic [INDEX_WIDTH-1:0]         rd_index_2,
  output logic                           fwd_hit_1,
  output logic [DATA_WIDTH-1:0]          fwd_data_1,
  output logic                           fwd_hit_2,
  output logic [DATA_WIDTH-1:0]          fwd_data_2,
  output logic                           write_enable,
  output logic [INDEX_WIDTH-1:0]         write_index,
  output logic [DATA_WIDTH-1:0]          write_data,
  output logic [$clog2(DEPTH+1)-1:0]     pending_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0]       ent_valid_q, ent_valid_d;
  logic [INDEX_WIDTH-1:0] ent_index_q [DEPTH];
  logic [INDEX_WIDTH-1:0] ent_index_d [DEPTH];
  logic [DATA_WIDTH-1:0]  ent_data_q  [DEPTH];
  logic [DATA_WIDTH-1:0]  ent_data_d  [DEPTH];
  logic [PW-1:0]          head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]          count_q, count_d;
  logic                   we_q, we_d;
  logic [INDEX_WIDTH-1:0] wi_q, wi_d;
  logic [DATA_WIDTH-1:0]  wd_q, wd_d;
  logic                   push, pop;

  assign load_ready    = !reset && (count_q < CW'(DEPTH));
  assign push          = load_valid && load_ready;
  assign pop           = !alu_valid && (count_q != '0);
  assign write_enable  = we_q;
  assign write_index   = wi_q;
  assign write_data    = wd_q;
  assign pending_count = count_q;

  always_comb begin
    ent_valid_d = ent_valid_q;
    ent_index_d = ent_index_q;
    ent_data_d  = ent_data_q;
    head_d      = head_q;
    tail_d      = tail_q;
    we_d        = 1'b0;
    wi_d        = wi_q;
    wd_d        = wd_q;

    if (alu_valid) begin
      // The ALU result is younger than every queued load, so matching loads must not land.
      for (int i = 0; i < DEPTH; i++) begin
        if (ent_index_q[i] == alu_index) ent_valid_d[i] = 1'b0;
      end
      we_d = 1'b1;
      wi_d = alu_index;
      wd_d = alu_data;
    end else if (pop) begin
      we_d                = ent_valid_q[head_q];
      wi_d                = ent_index_q[head_q];
      wd_d                = ent_data_q[head_q];
      ent_valid_d[head_q] = 1'b0;
      head_d              = head_q + PW'(1);
    end

    // Tail slot is free whenever push is allowed, so this never collides with the squash.
    if (push) begin
      ent_valid_d[tail_q] = 1'b1;
      ent_index_d[tail_q] = load_index;
      ent_data_d[tail_q]  = load_data;
      tail_d              = tail_q + PW'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ent_valid_q <= '0;
      ent_index_q <= '{default: '0};
      ent_data_q  <= '{default: '0};
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      we_q        <= 1'b0;
      wi_q        <= '0;
      wd_q        <= '0;
    end else begin
      ent_valid_q <= ent_valid_d;
      ent_index_q <= ent_index_d;
      ent_data_q  <= ent_data_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      we_q        <= we_d;
      wi_q        <= wi_d;
      wd_q        <= wd_d;
    end
  end

  // Returns {hit, data}; later assignments override earlier ones to express priority.
  function automatic logic [DATA_WIDTH:0] lookup(input logic [INDEX_WIDTH-1:0] rd);
    logic [DATA_WIDTH:0] r;
    logic [PW-1:0]       pos;
    r = '0;
    if (we_q && wi_q == rd) r = {1'b1, wd_q};
    for (int i = 0; i < DEPTH; i++) begin
      pos = head_q + PW'(i);
      if (CW'(i) < count_q && ent_valid_q[pos] && ent_index_q[pos] == rd)
        r = {1'b1, ent_data_q[pos]};
    end
    if (alu_valid && alu_index == rd) r = {1'b1, alu_data};
    return r;
  endfunction

  always_comb begin
    {fwd_hit_1, fwd_data_1} = lookup(rd_index_1);
    {fwd_hit_2, fwd_data_2} = lookup(rd_index_2);
  end

endmodule
